// File: rtl/gf2_mul_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial GF(2) multiplier.
package gf2_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/gf2_digit_clmul.sv
// Combinational N x D carry-less multiply: XOR of D shifted copies of A,
// each copy gated by the corresponding digit bit.
module gf2_digit_clmul #(
    parameter int N = 17669,
    parameter int D = 64
) (
    input  logic [N-1:0]   a_i,
    input  logic [D-1:0]   digit_i,
    output logic [N+D-2:0] prod_o
);

    localparam int PW = N + D - 1;

    logic [PW-1:0] a_ext_s;
    logic [PW-1:0] sum_s;

    assign a_ext_s = PW'(a_i);

    // Partial-product reduction over the digit bits
    always_comb begin
        sum_s = '0;
        for (int j = 0; j < D; j++) begin
            sum_s = sum_s ^ ((a_ext_s << j) & {PW{digit_i[j]}});
        end
    end

    assign prod_o = sum_s;

endmodule

// File: rtl/gf2_digit_serial_mult.sv
// Digit-serial carry-less multiplier: Horner accumulation of B digits (MSB first),
// with an optional fold that reduces the product modulo x^N - 1.
module gf2_digit_serial_mult
    import gf2_mul_pkg::*;
#(
    parameter int N = 17669,
    parameter int D = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           cyclic,
    input  logic [N-1:0]   U,
    input  logic [N-1:0]   V,
    output logic [2*N-1:0] W,
    output logic           busy,
    output logic           done
);

    localparam int K  = ceil_div(N, D);
    localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);
    localparam int BW = K * D;
    localparam int AW = 2 * N - 1 + D;
    localparam int PW = N + D - 1;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  w_q, w_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [D-1:0]    digit_s;
    logic [PW-1:0]   prod_s;
    logic [N-1:0]    hi_s;

    // B is shifted up each MUL cycle, so the current digit always sits at the top
    assign digit_s = b_q[BW-1 -: D];
    assign hi_s    = {1'b0, acc_q[2*N-2:N]};

    gf2_digit_clmul #(
        .N (N),
        .D (D)
    ) u_clmul (
        .a_i     (a_q),
        .digit_i (digit_s),
        .prod_o  (prod_s)
    );

    // Next-state and datapath update for the multiply sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = U;
                    b_d     = BW'(V);
                    cyc_d   = cyclic;
                    acc_d   = '0;
                    cnt_d   = CW'(K - 1);
                    state_d = MUL;
                end else begin
                    state_d = state_q;
                end
            end
            MUL: begin
                acc_d = (acc_q << D) ^ AW'(prod_s);
                b_d   = b_q << D;
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    if (cyc_q) begin
                        state_d = FOLD;
                    end else begin
                        state_d = DONE;
                        w_d     = acc_d[2*N-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FOLD: begin
                acc_d   = AW'(acc_q[N-1:0] ^ hi_s);
                w_d     = acc_d[2*N-1:0];
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == MUL) || (state_d == FOLD);
        done_d = (state_d == DONE);
    end

    // State, operand, accumulator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cyc_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign W    = w_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/gf2_digit_serial_mult.md
Name: gf2_digit_serial_mult

Overview:
- Parametrised sequential carry-less (GF(2)) polynomial multiplier; successor to the fixed-width CompleteMultiplier.
- Consumes D coefficients of operand B per cycle (digit-serial Horner), so area/latency trades via D.
- Adds a selectable cyclic mode returning A·B mod (x^N − 1), as needed for quasi-cyclic code arithmetic (N = 17669 class), alongside the plain full product.
- Sits between the operand register file and the syndrome/encode datapath; start/done handshake.

Parameters:
- N, 17669, operand length in coefficients; bit i of a vector is the coefficient of x^i.
- D, 64, digit width (B coefficients absorbed per cycle), 1 <= D <= N.
- K (derived, localparam), ceil(N/D), number of accumulate cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; accepted only in IDLE or DONE.
- cyclic  in  1  mode, sampled with start: 0 = full product, 1 = reduce mod x^N − 1.
- U  in  N  operand A, sampled on the accepted start cycle.
- V  in  N  operand B, sampled on the accepted start cycle.
- W  out  2N  result; linear: W[2N-2:0] = A·B, W[2N-1] = 0; cyclic: W[N-1:0] = A·B mod (x^N−1), W[2N-1:N] = 0.
- busy  out  1  high in MUL or FOLD.
- done  out  1  level; high in DONE until the next accepted start or reset.

Behaviour:
- Reset values: W = 0, busy = 0, done = 0, state = IDLE, internal accumulator/counter/operand regs = 0.
- States: IDLE, MUL, FOLD, DONE.
- IDLE/DONE + start=1: latch U, V (B zero-padded to K·D bits at the top), latch cyclic, clear accumulator, digit counter = K−1, done <= 0, go to MUL.
- MUL, each cycle: acc <= (acc << D) XOR clmul(A, digit), where digit = B[counter·D +: D] (MSB digit first). Counter decrements; after the counter-0 digit, go to FOLD if cyclic, else DONE.
- FOLD, one cycle: acc[N-1:0] <= acc[N-1:0] XOR acc[2N-2:N]; upper bits cleared; go to DONE.
- On entry to DONE: W <= acc (registered), done <= 1.
- Latency: done rises in the cycle following the accepted start edge + K + 1 edges (linear) or K + 2 edges (cyclic). Example: N=8, D=3 → 4 or 5 edges.
- W holds the previous result through a new operation until DONE is re-entered. W is valid whenever done=1.
- start during MUL/FOLD: ignored, with no effect on the operation in flight; U/V/cyclic are not re-sampled.
- start in DONE: restarts; done drops on the following edge.
- Reset asserted mid-operation: immediate return to reset values; no partial result is exposed.
- Accumulator width: 2N−1+D bits. The bits above 2N−2 must be zero at the end of MUL, which holds because of the top zero padding. Shifted-out bits are never set.
- D = N degenerates to K = 1, giving a single accumulate cycle.

Decomposition:
- Package gf2_mul_pkg contains:
  - state enum (IDLE, MUL, FOLD, DONE);
  - function ceil_div;
  - function clog2, used for the counter width.
- One natural sub-module, gf2_digit_clmul: combinational N × D carry-less multiply, output N+D−1 bits, built as an XOR of D shifted copies of A gated by digit bits.
- The FSM, accumulator and fold logic stay in the top module.

Test Plan:
- N=8, D=3, cyclic=0, U=0x03, V=0x03 → W=0x0005; done rises exactly 4 edges after start; busy high for cycles 1–3.
- N=8, D=3, U=0x80, V=0x80: cyclic=0 → W=0x4000; cyclic=1 → W=0x0040 (x^14 mod x^8−1 = x^6), done after 5 edges.
- N=8, D=3, U=0xFF, V=0x01, cyclic=1 → W=0x00FF; then back-to-back start from DONE with U=0x00 → W=0x0000, and done deasserts for the intermediate cycles.
- Mid-operation: assert reset 2 edges after start → W=0, done=0, busy=0 immediately; a fresh start then gives the correct result. A start pulse during MUL is ignored and the result matches the original operands.
- N=17669, D=64, U=4892378128957813477589134, V=2398457699321345184592348, both modes → W matches the schoolbook GF(2) model (cyclic: model result folded mod x^17669−1); done after K+1=278 / K+2=279 edges.
- N=17669, D=1 and D=N corner configurations, 20 random operand pairs each → bit-exact match with the model; no X on W when done=1.
